// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-issue instruction fetch and issue sequencer.
// It fetches the word at the current PC, hands it to decode with a one-cycle
// d_valid strobe, and then waits for every completion pulse that the
// instruction class requires before it fetches the next word.
// The opcode and func encodings are MIPS-style. The non-MIPS members are
// SGT (SPECIAL func 101011), SGTI (001011), LWC2 (110010) and SWC2 (111010).
module fetch_ctrl #(
  parameter int IMEM_LATENCY = 2,
  parameter int WAIT_LIMIT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [12:0] o_addr,
  output logic [12:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] op,
  output logic        d_valid,
  input  logic        jump_finish,
  input  logic        write_finish,
  input  logic        load_finish,
  input  logic        store_finish,
  input  logic        uart_send_done,
  output logic        busy,
  output logic [31:0] retired,
  output logic        stall_err
);

  localparam int LAT_W  = $clog2(IMEM_LATENCY + 1);
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  // Completion-mask bit positions: jump, write, load, store, uart.
  localparam logic [4:0] M_J = 5'b00001;
  localparam logic [4:0] M_W = 5'b00010;
  localparam logic [4:0] M_L = 5'b00100;
  localparam logic [4:0] M_S = 5'b01000;
  localparam logic [4:0] M_U = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [4:0]          flags_q, flags_d;
  logic [4:0]          mask_q, mask_d;
  logic [12:0]         i_addr_q, i_addr_d;
  logic [31:0]         op_q, op_d;
  logic [31:0]         retired_q, retired_d;
  logic                stall_q, stall_d;
  logic [4:0]          pulses;
  logic                done;

  // Returns the set of completion pulses that an instruction class must produce.
  function automatic logic [4:0] class_mask(input logic [5:0] opc,
                                            input logic [4:0] fmt,
                                            input logic [5:0] func);
    logic [4:0] m;
    m = M_J;
    case (opc)
      6'b000000: begin  // SPECIAL
        case (func)
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b001001, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
          6'b101010, 6'b101011: m = M_J | M_W;
          default:              m = M_J;  // JR and unknown funcs
        endcase
      end
      6'b001000, 6'b001101, 6'b001010, 6'b001011, 6'b001111, 6'b000011,
      6'b110010:            m = M_J | M_W;         // ADDI ORI SLTI SGTI LUI JAL LWC2
      6'b100011, 6'b110001: m = M_J | M_L | M_W;   // LW LWC1
      6'b101011, 6'b111001: m = M_J | M_S;         // SW SWC1
      6'b111010:            m = M_J | M_U;         // SWC2 (UART send)
      6'b010001: begin  // COP1
        if (fmt == 5'b01000) begin
          m = M_J;  // BC1T / BC1F
        end else if (func[5:4] == 2'b11) begin
          m = M_J | M_W;
        end else begin
          case (func)
            6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
            6'b000110, 6'b001000, 6'b001001, 6'b001100, 6'b100000: m = M_J | M_W;
            default:                                               m = M_J;
          endcase
        end
      end
      default: m = M_J;  // J BEQ BNE and unknown opcodes
    endcase
    return m;
  endfunction

  assign pulses = {uart_send_done, store_finish, load_finish, write_finish, jump_finish};
  // Pulses in the current cycle count toward completion, so the instruction
  // retires in the same cycle that its last required pulse arrives.
  assign done   = ((flags_q | pulses) & mask_q) == mask_q;

  // Next-state and datapath update for the fetch/issue/wait sequence.
  always_comb begin
    // NOTE: every _d signal gets a hold default first so that no path through
    // the case infers a latch.
    state_d   = state_q;
    lat_d     = lat_q;
    wait_d    = wait_q;
    flags_d   = flags_q;
    mask_d    = mask_q;
    i_addr_d  = i_addr_q;
    op_d      = op_q;
    retired_d = retired_q;
    stall_d   = stall_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_FETCH;
          i_addr_d = o_addr;
          lat_d    = '0;
        end
      end
      S_FETCH: begin
        if (lat_q == LAT_W'(IMEM_LATENCY)) begin
          op_d    = i_data;
          state_d = S_ISSUE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_ISSUE: begin
        flags_d = '0;
        mask_d  = class_mask(op_q[31:26], op_q[25:21], op_q[5:0]);
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        flags_d = flags_q | pulses;
        if (done) begin
          retired_d = retired_q + 32'd1;
          if (run) begin
            state_d  = S_FETCH;
            i_addr_d = o_addr;
            lat_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
          // The counter would reach WAIT_LIMIT here. A completion in this
          // same cycle has already taken the branch above.
          state_d = S_HALT;
          stall_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so that every
    // register samples the pre-edge value of every other register.
    if (rst) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      wait_q    <= '0;
      flags_q   <= '0;
      mask_q    <= '0;
      i_addr_q  <= '0;
      op_q      <= '0;
      retired_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      wait_q    <= wait_d;
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      i_addr_q  <= i_addr_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign i_addr    = i_addr_q;
  assign op        = op_q;
  assign d_valid   = (state_q == S_ISSUE);
  assign busy      = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign retired   = retired_q;
  assign stall_err = stall_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed bench for fetch_ctrl, with a BRAM model.
// Expected issue cycles, retire cycles and counts come from a per-instruction
// model. The retire offset is the latest first-arrival offset among the
// required pulses, and a stall occurs when that offset lies beyond WAIT_LIMIT.
module tb_fetch_ctrl;

  localparam int L   = 2;
  localparam int LIM = 8;
  localparam int INF = 1000;

  localparam logic [4:0] MJ = 5'b00001;
  localparam logic [4:0] MW = 5'b00010;
  localparam logic [4:0] ML = 5'b00100;
  localparam logic [4:0] MS = 5'b01000;
  localparam logic [4:0] MU = 5'b10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [12:0] o_addr;
  logic [12:0] i_addr;
  logic [31:0] i_data;
  logic [31:0] op;
  logic        d_valid;
  logic        jump_finish, write_finish, load_finish, store_finish, uart_send_done;
  logic        busy;
  logic [31:0] retired;
  logic        stall_err;

  fetch_ctrl #(.IMEM_LATENCY(L), .WAIT_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .run(run), .o_addr(o_addr), .i_addr(i_addr),
    .i_data(i_data), .op(op), .d_valid(d_valid), .jump_finish(jump_finish),
    .write_finish(write_finish), .load_finish(load_finish),
    .store_finish(store_finish), .uart_send_done(uart_send_done), .busy(busy),
    .retired(retired), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  // Instruction BRAM with a read latency of L cycles.
  logic [31:0] mem [0:8191];
  logic [31:0] rd1;
  always @(posedge clk) begin
    rd1    <= mem[i_addr];
    i_data <= rd1;
  end

  typedef struct {
    logic [31:0] base;
    logic [31:0] keep;
    logic [4:0]  m;
  } ent_t;
  ent_t tbl[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          exp_issue;
  logic [31:0] exp_ret;
  logic [12:0] cur_pc;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_pulses(input logic [4:0] p);
    jump_finish    = p[0];
    write_finish   = p[1];
    load_finish    = p[2];
    store_finish   = p[3];
    uart_send_done = p[4];
  endtask

  task automatic add(input logic [31:0] b, input logic [31:0] k, input logic [4:0] m);
    ent_t e;
    e.base = b; e.keep = k; e.m = m;
    tbl.push_back(e);
  endtask

  task automatic start_run();
    run       = 1'b1;
    cur_pc    = o_addr;
    exp_issue = cyc + 2 + L;
  endtask

  task automatic test_reset(input string tag);
    rst = 1'b1;
    set_pulses(5'b0);
    tick();
    n_checks++; if (d_valid !== 1'b0) $display("FAIL %s d_valid: got %b want 0", tag, d_valid); else n_pass++;
    n_checks++; if (op !== 32'h0) $display("FAIL %s op: got %h want 0", tag, op); else n_pass++;
    n_checks++; if (i_addr !== 13'h0) $display("FAIL %s i_addr: got %h want 0", tag, i_addr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL %s busy: got %b want 0", tag, busy); else n_pass++;
    n_checks++; if (retired !== 32'h0) $display("FAIL %s retired: got %0d want 0", tag, retired); else n_pass++;
    n_checks++; if (stall_err !== 1'b0) $display("FAIL %s stall_err: got %b want 0", tag, stall_err); else n_pass++;
    rst     = 1'b0;
    run     = 1'b0;
    exp_ret = '0;
  endtask

  task automatic wait_issue();
    int budget;
    budget = 40;
    while (d_valid !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (d_valid !== 1'b1) $display("FAIL issue_timeout: d_valid=%b after 40 cycles, want 1", d_valid);
    else if (cyc != exp_issue) $display("FAIL issue_cycle: got cycle %0d want %0d", cyc, exp_issue);
    else n_pass++;
  endtask

  // Runs one instruction. An offset t means the pulse is high in cycle ISSUE+t,
  // and 0 means the pulse never arrives.
  task automatic do_instr(input logic [31:0] w, input logic [4:0] m,
                          input int oj, input int ow, input int ol, input int os,
                          input int ou, input logic run_lvl, input logic [12:0] new_pc);
    int         off[5];
    int         tc;
    int         v;
    logic [4:0] p;
    off[0] = oj; off[1] = ow; off[2] = ol; off[3] = os; off[4] = ou;
    tc = 0;
    for (int b = 0; b < 5; b++) begin
      if (m[b]) begin
        v  = (off[b] < 1) ? INF : off[b];
        tc = (v > tc) ? v : tc;
      end
    end
    mem[cur_pc] = w;
    wait_issue();
    n_checks++; if (op !== w) $display("FAIL issue_op: got %h want %h", op, w); else n_pass++;
    n_checks++; if (i_addr !== cur_pc) $display("FAIL issue_addr: got %h want %h", i_addr, cur_pc); else n_pass++;
    set_pulses(5'($urandom));  // pulses during ISSUE must be ignored
    tick();
    set_pulses(5'b0);
    n_checks++; if (d_valid !== 1'b0) $display("FAIL single_dvalid: got %b want 0", d_valid); else n_pass++;
    run = run_lvl;
    for (int t = 1; t <= LIM; t++) begin
      for (int b = 0; b < 5; b++)
        p[b] = (off[b] == t) || (off[b] > 0 && t > off[b] && $urandom_range(0, 2) == 0);
      set_pulses(p);
      if (t == oj) o_addr = new_pc;
      tick();
      set_pulses(5'b0);
      if (t == tc) begin
        exp_ret = exp_ret + 32'd1;
        n_checks++; if (retired !== exp_ret) $display("FAIL retire_count: got %0d want %0d", retired, exp_ret); else n_pass++;
        n_checks++; if (busy !== run_lvl) $display("FAIL retire_busy: got %b want %b", busy, run_lvl); else n_pass++;
        n_checks++; if (stall_err !== 1'b0) $display("FAIL retire_stall: got %b want 0", stall_err); else n_pass++;
        if (run_lvl) begin
          n_checks++; if (i_addr !== new_pc) $display("FAIL next_addr: got %h want %h", i_addr, new_pc); else n_pass++;
          cur_pc    = new_pc;
          exp_issue = cyc + 1 + L;
        end
        break;
      end else if (t == LIM) begin
        n_checks++; if (stall_err !== 1'b1) $display("FAIL halt_stall: got %b want 1", stall_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL halt_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (retired !== exp_ret) $display("FAIL halt_retired: got %0d want %0d", retired, exp_ret); else n_pass++;
      end else begin
        n_checks++; if (retired !== exp_ret) $display("FAIL early_retire t=%0d: got %0d want %0d", t, retired, exp_ret); else n_pass++;
        n_checks++; if (d_valid !== 1'b0 || busy !== 1'b1 || stall_err !== 1'b0)
          $display("FAIL wait_state t=%0d: got dv=%b busy=%b stall=%b want 0/1/0", t, d_valid, busy, stall_err);
        else n_pass++;
      end
    end
  endtask

  task automatic test_addi();
    o_addr = 13'h0;
    start_run();
    do_instr(32'h20020005, MJ | MW, 1, 3, 0, 0, 0, 1'b1, 13'h1);
  endtask

  task automatic test_beq();
    do_instr(32'h10430004, MJ, 2, 2, 0, 0, 0, 1'b1, 13'h40);
  endtask

  task automatic test_lw();
    do_instr(32'h8C220000, MJ | ML | MW, 1, 5, 2, 0, 0, 1'b1, 13'h41);
  endtask

  task automatic test_swc2_idle();
    do_instr(32'hE8010000, MJ | MU, 1, 0, 0, 0, 7, 1'b0, 13'h42);
    tick();
    n_checks++; if (busy !== 1'b0 || d_valid !== 1'b0) $display("FAIL idle_hold: got busy=%b dv=%b want 0/0", busy, d_valid); else n_pass++;
    o_addr = 13'h100;
    start_run();
    do_instr(32'h08000010, MJ, 1, 0, 0, 0, 0, 1'b1, 13'h101);
  endtask

  task automatic test_random();
    ent_t        e;
    logic [31:0] w;
    int          o[5];
    logic        rl;
    for (int i = 0; i < 30; i++) begin
      e = tbl[$urandom_range(0, tbl.size() - 1)];
      w = (e.base & e.keep) | ($urandom & ~e.keep);
      for (int b = 0; b < 5; b++) o[b] = e.m[b] ? $urandom_range(1, 6) : $urandom_range(0, 6);
      rl = ($urandom_range(0, 3) != 0);
      do_instr(w, e.m, o[0], o[1], o[2], o[3], o[4], rl, 13'($urandom));
      if (!rl) begin
        tick();
        tick();
        n_checks++; if (busy !== 1'b0 || d_valid !== 1'b0) $display("FAIL rand_idle: got busy=%b dv=%b want 0/0", busy, d_valid); else n_pass++;
        o_addr = 13'($urandom);
        start_run();
      end
    end
  endtask

  task automatic test_stall();
    test_reset("pre_stall");
    o_addr = 13'h20;
    start_run();
    do_instr(32'h00221820, MJ | MW, 1, 0, 0, 0, 0, 1'b1, 13'h21);
    for (int k = 0; k < 3; k++) begin
      set_pulses(5'b00011);
      tick();
      set_pulses(5'b0);
      n_checks++; if (d_valid !== 1'b0 || stall_err !== 1'b1 || retired !== exp_ret)
        $display("FAIL halt_absorb: got dv=%b stall=%b retired=%0d want 0/1/%0d", d_valid, stall_err, retired, exp_ret);
      else n_pass++;
    end
    test_reset("rst_halt");
  endtask

  task automatic late_pulses(input string tag);
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_pulses(5'b11111);
      tick();
      set_pulses(5'b0);
    end
    n_checks++; if (retired !== 32'h0 || busy !== 1'b0 || d_valid !== 1'b0)
      $display("FAIL %s: got retired=%0d busy=%b dv=%b want 0/0/0", tag, retired, busy, d_valid);
    else n_pass++;
  endtask

  task automatic test_reset_fetch();
    o_addr = 13'h5;
    start_run();
    mem[13'h5] = 32'h20020005;
    tick();
    tick();
    test_reset("rst_fetch");
    late_pulses("late_after_fetch_rst");
  endtask

  task automatic test_reset_wait();
    o_addr = 13'h7;
    start_run();
    mem[13'h7] = 32'h8C220000;
    wait_issue();
    tick();
    set_pulses(MJ);
    tick();
    set_pulses(ML);
    test_reset("rst_wait");
    late_pulses("late_after_wait_rst");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    add(32'h00000008, 32'hFC00003F, MJ);       // JR
    add(32'h00000020, 32'hFC00003F, MJ | MW);  // ADD
    add(32'h00000000, 32'hFC00003F, MJ | MW);  // SLL
    add(32'h0000002B, 32'hFC00003F, MJ | MW);  // SGT
    add(32'h00000007, 32'hFC00003F, MJ | MW);  // SRAV
    add(32'h00000009, 32'hFC00003F, MJ | MW);  // JALR
    add(32'h00000001, 32'hFC00003F, MJ);       // unknown SPECIAL func
    add(32'h20000000, 32'hFC000000, MJ | MW);  // ADDI
    add(32'h3C000000, 32'hFC000000, MJ | MW);  // LUI
    add(32'h2C000000, 32'hFC000000, MJ | MW);  // SGTI
    add(32'h0C000000, 32'hFC000000, MJ | MW);  // JAL
    add(32'hC8000000, 32'hFC000000, MJ | MW);  // LWC2
    add(32'h08000000, 32'hFC000000, MJ);       // J
    add(32'h14000000, 32'hFC000000, MJ);       // BNE
    add(32'h8C000000, 32'hFC000000, MJ | ML | MW);  // LW
    add(32'hC4000000, 32'hFC000000, MJ | ML | MW);  // LWC1
    add(32'hAC000000, 32'hFC000000, MJ | MS);  // SW
    add(32'hE4000000, 32'hFC000000, MJ | MS);  // SWC1
    add(32'hE8000000, 32'hFC000000, MJ | MU);  // SWC2
    add(32'h45000000, 32'hFFE00000, MJ);       // BC1T/BC1F
    add(32'h46000006, 32'hFFE0003F, MJ | MW);  // COP1 func 000110
    add(32'h4600000C, 32'hFFE0003F, MJ | MW);  // COP1 func 001100
    add(32'h46000020, 32'hFFE0003F, MJ | MW);  // COP1 func 100000
    add(32'h46000035, 32'hFFE0003F, MJ | MW);  // COP1 func 11xxxx
    add(32'h46000007, 32'hFFE0003F, MJ);       // COP1 func 000111
    add(32'h46000021, 32'hFFE0003F, MJ);       // COP1 func 100001
    add(32'hFC000000, 32'hFC000000, MJ);       // unknown opcode

    run = 1'b0;
    o_addr = 13'h0;
    set_pulses(5'b0);
    exp_ret = '0;
    cur_pc = '0;
    exp_issue = 0;
    rst = 1'b1;
    tick();
    test_reset("reset");
    test_addi();
    test_beq();
    test_lw();
    test_swc2_idle();
    test_random();
    test_stall();
    test_reset_fetch();
    test_reset_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch and issue sequencer sitting directly upstream of the decode/execute stage. It reads the instruction at the current PC from instruction BRAM and presents it to decode as `op` with a one-cycle `d_valid` pulse. It then collects the completion pulses that instruction must produce before fetching the next one. It is the only source of `d_valid` in the core, so the core never has more than one instruction in flight.

## Interface
- `IMEM_LATENCY`, 2: instruction BRAM read latency in cycles (≥1).
- `WAIT_LIMIT`, 4096: maximum cycles spent in WAIT before declaring a stall.
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `run`  in  1  enable; permits leaving IDLE and continuing after each retire.
- `o_addr`  in  13  current PC from the pc unit, via decode.
- `i_addr`  out  13  instruction BRAM address (registered).
- `i_data`  in  32  instruction BRAM read data.
- `op`  out  32  instruction word to decode.
- `d_valid`  out  1  one-cycle issue strobe to decode.
- `jump_finish`  in  1  pulse: PC updated. Every instruction produces it.
- `write_finish`  in  1  pulse: GPR or FPR written.
- `load_finish`  in  1  pulse: data memory load done.
- `store_finish`  in  1  pulse: data memory store done.
- `uart_send_done`  in  1  pulse: UART byte accepted.
- `busy`  out  1  state is FETCH, ISSUE or WAIT.
- `retired`  out  32  count of retired instructions; wraps at 2^32.
- `stall_err`  out  1  sticky: WAIT_LIMIT exceeded.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, HALT. Reset enters IDLE.
- **IDLE**:
  - If `run`=1, go to FETCH and register `i_addr <= o_addr`.
- **FETCH**:
  - Lasts IMEM_LATENCY+1 cycles, counted by a latency counter.
  - On the last cycle, register `op <= i_data` and go to ISSUE.
- **ISSUE**:
  - Exactly one cycle with `d_valid`=1.
  - Clear all sticky flags, load the required-mask from the class of `op`, clear the wait counter, go to WAIT.
- **Required-mask by `op[31:26]` / `op[5:0]`**. J = jump, W = write, L = load, S = store, U = uart send.
  - SPECIAL: JR gives J. ADD, SUB, AND, OR, NOR, SLL, SRL, SRA, SLLV, SRLV, SRAV, SLT, SGT, JALR give J+W. Any other func gives J.
  - ADDI, ORI, SLTI, SGTI, LUI, JAL, LWC2 give J+W.
  - J, BEQ, BNE give J.
  - LW, LWC1 give J+L+W.
  - SW, SWC1 give J+S.
  - SWC2 gives J+U.
  - COP1: BC1T, BC1F give J. Func 000000–000110, 001000, 001001, 001100, 100000, and any func with `op[5:4]`=11 give J+W. Any other func gives J.
  - Any other opcode gives J.
- **WAIT**:
  - Each finish input sets its sticky flag whether required or not.
  - Completion condition: (flags | this cycle's inputs) & mask == mask.
  - On completion:
    - Increment `retired`.
    - If `run`=1, go to FETCH and register `i_addr <= o_addr` (the pc unit guarantees `o_addr` already holds the new PC in the cycle `jump_finish` is high, or earlier).
    - If `run`=0, go to IDLE.
  - Otherwise, increment the wait counter. When it reaches WAIT_LIMIT, go to HALT and set `stall_err`=1.
- **HALT**: absorbing; only `rst` leaves it. `d_valid` stays 0.
- Finish pulses outside WAIT are ignored. Duplicate pulses are harmless.
- **Reset values**: `d_valid` 0, `op` 0, `i_addr` 0, `busy` 0, `retired` 0, `stall_err` 0. All flags and counters 0.
- **Reset mid-operation**: reset wins over every transition. Pulses for the aborted instruction that arrive after reset are ignored.

## Timing
- Issue latency: if the retiring cycle is C, `i_addr` is visible at C+1, `d_valid` and `op` are valid at C+2+IMEM_LATENCY.
- From IDLE: `run` sampled high at cycle R gives `d_valid` at R+2+IMEM_LATENCY.
- Earliest retire is the cycle after ISSUE, for a J-only instruction whose `jump_finish` arrives at ISSUE+1.
- Minimum instruction period is IMEM_LATENCY+3 cycles.
- `op` holds its value from ISSUE until the next FETCH capture.
- The stall check runs in the same cycle as the completion check. Completion in the WAIT_LIMIT-th cycle wins over HALT.

## Test plan
- Reset, `run`=1, BRAM[0]=ADDI (0x20020005), `jump_finish` at ISSUE+1, `write_finish` at ISSUE+3 → `d_valid` exactly at cycle 4 after `run`. Retire at ISSUE+3, `retired`=1. Next `i_addr` = `o_addr` (1).
- BEQ, with `jump_finish` and an unexpected `write_finish` in the same cycle → retires that cycle. Next fetch uses the updated `o_addr`.
- LW with `load_finish` at +2, `write_finish` at +5, `jump_finish` at +1 → no retire before +5. Exactly one `d_valid` per instruction.
- SWC2 with `jump_finish` only, then `run`=0 → stays in WAIT. `uart_send_done` at +7 → retires and goes to IDLE, `busy`=0. Raising `run` resumes.
- WAIT_LIMIT=8, ADD with `write_finish` never asserted → HALT at the 8th WAIT cycle, `stall_err`=1, no further `d_valid`. `rst` clears everything.
- `rst` asserted during FETCH and during WAIT → all outputs return to reset values next cycle. Late finish pulses do not change `retired`.
